// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Detects load-use and branch-operand hazards for the instruction in ID.
// Generates the bubble-mux select, the PC / IF/ID write enables and the
// IF/ID flush. Stalls that last more than one cycle are sequenced by a
// small state machine. A saturating counter records stalled cycles.
//
// Ports:
//   Clk, Rst_n        pipeline clock, asynchronous active-low reset
//   ifid_rs/rt        source register fields of the ID instruction
//   id_uses_rs/rt     ID instruction actually reads rs / rt
//   id_is_branch      ID instruction is a conditional branch (compare in ID)
//   idex_dst          destination of the ID/EX instruction (after RegDst)
//   idex_reg_write    ID/EX instruction writes a register
//   idex_mem_read     ID/EX instruction is a load
//   exmem_dst         destination of the EX/MEM instruction
//   exmem_mem_read    EX/MEM instruction is a load
//   branch_taken      branch resolved taken in ID this cycle
//   jump              jump in ID this cycle
//   ctrl_bubble       1 forces all ID control signals to 0
//   pc_write          PC register enable
//   ifid_write        IF/ID register enable
//   ifid_flush        clear IF/ID to a NOP on this edge
//   stall_cycles      saturating count of cycles with ctrl_bubble=1
//
// Handshake: there is no valid/ready pair. A stalled cycle is one where
// ctrl_bubble=1; in that cycle pc_write and ifid_write are 0 and the
// upstream stages hold their contents.
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic [REG_ADDR_W-1:0] ifid_rs,
    input  logic [REG_ADDR_W-1:0] ifid_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_is_branch,
    input  logic [REG_ADDR_W-1:0] idex_dst,
    input  logic                  idex_reg_write,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] exmem_dst,
    input  logic                  exmem_mem_read,
    input  logic                  branch_taken,
    input  logic                  jump,
    output logic                  ctrl_bubble,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  ifid_flush,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       remain_q, remain_d;
    logic [CNT_W-1:0] cnt_q;

    logic       idex_match;
    logic       exmem_match;
    logic [1:0] need_n;
    logic       stall_active;

    // Register 0 is hard-wired, so it never produces a hazard.
    always_comb begin
        idex_match  = (id_uses_rs && (ifid_rs != '0) && (ifid_rs == idex_dst)) ||
                      (id_uses_rt && (ifid_rt != '0) && (ifid_rt == idex_dst));
        exmem_match = (id_uses_rs && (ifid_rs != '0) && (ifid_rs == exmem_dst)) ||
                      (id_uses_rt && (ifid_rt != '0) && (ifid_rt == exmem_dst));
    end

    // Stall need. Branches compare in ID, so they must also wait for ALU
    // results (1 cycle) and loads (2 cycles in ID/EX, 1 cycle in EX/MEM).
    // Checks are ordered largest-first so the largest need wins.
    always_comb begin
        need_n = 2'd0;
        if (id_is_branch) begin
            if (idex_match && idex_reg_write && idex_mem_read) begin
                need_n = 2'd2;
            end else if (idex_match && idex_reg_write) begin
                need_n = 2'd1;
            end else if (!idex_match && exmem_match && exmem_mem_read) begin
                need_n = 2'd1;
            end
        end else if (idex_match && idex_mem_read) begin
            need_n = 2'd1;
        end
    end

    // Need is only looked at in IDLE; once in STALL the inputs are ignored
    // because the bubble already cleared the ID/EX view of the producer.
    assign stall_active = (state_q == S_STALL) || (need_n != 2'd0);

    // Same-cycle outputs: the bubble must be inserted in the detect cycle.
    // Reset holds the front end frozen with a flushed IF/ID.
    always_comb begin
        ctrl_bubble = !Rst_n || stall_active;
        pc_write    = Rst_n && !stall_active;
        ifid_write  = Rst_n && !stall_active;
        ifid_flush  = !Rst_n || (!stall_active && (branch_taken || jump));
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            S_IDLE: begin
                if (need_n != 2'd0) begin
                    remain_d = need_n - 2'd1;
                    state_d  = (need_n > 2'd1) ? S_STALL : S_IDLE;
                end
            end
            S_STALL: begin
                remain_d = remain_q - 2'd1;
                // remain_q==0 is unreachable here; treat it as done too.
                state_d  = (remain_q <= 2'd1) ? S_IDLE : S_STALL;
            end
            default: begin
                state_d  = S_IDLE;
                remain_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            remain_q <= 2'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            if (stall_active && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_unit
//
// Table of single-cycle vectors (each starts and ends in IDLE), followed by
// hand-written multi-cycle sequences: load-use, load-branch double stall,
// ALU-branch, $0 producer, flush suppression during stall, reset in
// mid-stall, and counter saturation (counter narrowed to 4 bits).
// ---------------------------------------------------------------------------
module tb_hazard_stall_unit;

    localparam int RW      = 5;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic [RW-1:0] ifid_rs, ifid_rt, idex_dst, exmem_dst;
    logic          id_uses_rs, id_uses_rt, id_is_branch;
    logic          idex_reg_write, idex_mem_read, exmem_mem_read;
    logic          branch_taken, jump;
    logic          ctrl_bubble, pc_write, ifid_write, ifid_flush;
    logic [CW-1:0] stall_cycles;

    hazard_stall_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_is_branch   (id_is_branch),
        .idex_dst       (idex_dst),
        .idex_reg_write (idex_reg_write),
        .idex_mem_read  (idex_mem_read),
        .exmem_dst      (exmem_dst),
        .exmem_mem_read (exmem_mem_read),
        .branch_taken   (branch_taken),
        .jump           (jump),
        .ctrl_bubble    (ctrl_bubble),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .stall_cycles   (stall_cycles)
    );

    // ---------------- vector table ----------------
    typedef struct {
        string         name;
        logic [RW-1:0] rs, rt;
        logic          urs, urt, br;
        logic [RW-1:0] idst;
        logic          irw, imr;
        logic [RW-1:0] edst;
        logic          emr, bt, j;
        logic          exp_bub, exp_flush;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs[NVEC];

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic exp_bub, input logic exp_flush);
        check({name, "/ctrl_bubble"}, 32'(ctrl_bubble), 32'(exp_bub));
        check({name, "/pc_write"},    32'(pc_write),    32'(!exp_bub));
        check({name, "/ifid_write"},  32'(ifid_write),  32'(!exp_bub));
        check({name, "/ifid_flush"},  32'(ifid_flush),  32'(exp_flush));
    endtask

    // Advance one clock edge; the expected counter follows the expected bubble.
    task automatic tick(input string name, input logic exp_bub);
        @(posedge Clk);
        if (exp_bub && exp_cnt != CNT_MAX) exp_cnt++;
        #1;
        check({name, "/stall_cycles"}, 32'(stall_cycles), 32'(exp_cnt));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic urs, input logic urt, input logic br,
                         input logic [RW-1:0] idst, input logic irw, input logic imr,
                         input logic [RW-1:0] edst, input logic emr,
                         input logic bt, input logic j);
        ifid_rs = rs; ifid_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_is_branch = br; idex_dst = idst; idex_reg_write = irw;
        idex_mem_read = imr; exmem_dst = edst; exmem_mem_read = emr;
        branch_taken = bt; jump = j;
    endtask

    task automatic clear_inputs();
        drive('0, '0, 0, 0, 0, '0, 0, 0, '0, 0, 0, 0);
    endtask

    // Watchdog: the flow has no open-ended waits, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            name        rs   rt  urs urt br idst irw imr edst emr bt j  bub fl
        vecs[0]  = '{"no_haz",    5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 1, 5'd4, 1, 0, 0, 0, 0};
        vecs[1]  = '{"lu_rs",     5'd8, 5'd2, 1, 1, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, 1, 0};
        vecs[2]  = '{"lu_rt",     5'd3, 5'd8, 1, 1, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, 1, 0};
        vecs[3]  = '{"rs_unused", 5'd8, 5'd2, 0, 1, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0, 0, 0};
        vecs[4]  = '{"reg0_load", 5'd0, 5'd0, 1, 1, 0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0};
        vecs[5]  = '{"alu_fwd",   5'd10,5'd2, 1, 1, 0, 5'd10,1, 0, 5'd0, 0, 0, 0, 0, 0};
        vecs[6]  = '{"br_alu",    5'd10,5'd2, 1, 1, 1, 5'd10,1, 0, 5'd0, 0, 0, 0, 1, 0};
        vecs[7]  = '{"br_exm_ld", 5'd4, 5'd11,1, 1, 1, 5'd3, 1, 0, 5'd11,1, 0, 0, 1, 0};
        vecs[8]  = '{"br_exm_alu",5'd4, 5'd11,1, 1, 1, 5'd3, 1, 0, 5'd11,0, 0, 0, 0, 0};
        vecs[9]  = '{"nb_exm_ld", 5'd11,5'd2, 1, 1, 0, 5'd3, 1, 0, 5'd11,1, 0, 0, 0, 0};
        vecs[10] = '{"jump",      5'd1, 5'd2, 1, 1, 0, 5'd3, 1, 0, 5'd4, 0, 0, 1, 0, 1};
        vecs[11] = '{"br_taken",  5'd1, 5'd2, 1, 1, 1, 5'd3, 1, 0, 5'd4, 0, 1, 0, 0, 1};
        vecs[12] = '{"br_haz_tkn",5'd1, 5'd10,1, 1, 1, 5'd10,1, 0, 5'd4, 0, 1, 1, 1, 0};
        vecs[13] = '{"br_idex_nw",5'd6, 5'd2, 1, 1, 1, 5'd6, 0, 0, 5'd0, 0, 0, 0, 0, 0};

        // ---- reset state ----
        clear_inputs();
        #2;
        check_outs("reset", 1'b1, 1'b1);
        check("reset/stall_cycles", 32'(stall_cycles), 32'd0);
        #20 Rst_n = 1'b1;          // release between edges (t=22)
        @(posedge Clk); #1;

        // ---- table-driven single-cycle vectors ----
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].br,
                  vecs[i].idst, vecs[i].irw, vecs[i].imr, vecs[i].edst,
                  vecs[i].emr, vecs[i].bt, vecs[i].j);
            #2;
            check_outs(vecs[i].name, vecs[i].exp_bub, vecs[i].exp_flush);
            tick(vecs[i].name, vecs[i].exp_bub);
        end

        // ---- load-use: lw $8 then add $8 ----
        drive(5'd8, 5'd9, 1, 1, 0, 5'd8, 1, 1, 5'd0, 0, 0, 0);
        #2; check_outs("lu_c0", 1'b1, 1'b0);
        tick("lu_c0", 1'b1);
        drive(5'd8, 5'd9, 1, 1, 0, 5'd0, 0, 0, 5'd8, 1, 0, 0);
        #2; check_outs("lu_c1", 1'b0, 1'b0);
        tick("lu_c1", 1'b0);

        // ---- lw $9 then beq $9: two stall cycles ----
        drive(5'd9, 5'd0, 1, 1, 1, 5'd9, 1, 1, 5'd0, 0, 0, 0);
        #2; check_outs("lb_c0", 1'b1, 1'b0);
        tick("lb_c0", 1'b1);
        drive(5'd9, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd9, 1, 0, 0);
        #2; check_outs("lb_c1", 1'b1, 1'b0);
        tick("lb_c1", 1'b1);
        drive(5'd9, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        #2; check_outs("lb_c2", 1'b0, 1'b0);
        tick("lb_c2", 1'b0);

        // ---- ALU write $10 then beq $10: one stall cycle ----
        drive(5'd10, 5'd0, 1, 1, 1, 5'd10, 1, 0, 5'd0, 0, 0, 0);
        #2; check_outs("ab_c0", 1'b1, 1'b0);
        tick("ab_c0", 1'b1);
        drive(5'd10, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd10, 0, 0, 0);
        #2; check_outs("ab_c1", 1'b0, 1'b0);
        tick("ab_c1", 1'b0);

        // ---- load to $0, branch reading $0: never stalls ----
        drive(5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0);
        #2; check_outs("z_c0", 1'b0, 1'b0);
        tick("z_c0", 1'b0);
        drive(5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd0, 1, 0, 0);
        #2; check_outs("z_c1", 1'b0, 1'b0);
        tick("z_c1", 1'b0);

        // ---- load-branch stall with branch_taken high: flush held off ----
        drive(5'd7, 5'd0, 1, 1, 1, 5'd7, 1, 1, 5'd0, 0, 1, 0);
        #2; check_outs("fl_c0", 1'b1, 1'b0);
        tick("fl_c0", 1'b1);
        drive(5'd7, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd7, 1, 1, 0);
        #2; check_outs("fl_c1", 1'b1, 1'b0);
        tick("fl_c1", 1'b1);
        drive(5'd7, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        #2; check_outs("fl_c2", 1'b0, 1'b1);
        tick("fl_c2", 1'b0);

        // ---- reset during the second cycle of a two-cycle stall ----
        drive(5'd9, 5'd0, 1, 1, 1, 5'd9, 1, 1, 5'd0, 0, 0, 0);
        #2; check_outs("rs_c0", 1'b1, 1'b0);
        tick("rs_c0", 1'b1);
        drive(5'd9, 5'd0, 1, 1, 1, 5'd0, 0, 0, 5'd9, 1, 0, 0);
        #2; check_outs("rs_c1", 1'b1, 1'b0);
        Rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        check_outs("rs_held", 1'b1, 1'b1);
        check("rs_held/stall_cycles", 32'(stall_cycles), 32'd0);
        clear_inputs();
        @(posedge Clk); #2;
        Rst_n = 1'b1;
        #2; check_outs("rs_rel0", 1'b0, 1'b0);
        tick("rs_rel0", 1'b0);
        #2; check_outs("rs_rel1", 1'b0, 1'b0);
        tick("rs_rel1", 1'b0);

        // ---- saturation: back-to-back load-use stalls past all-ones ----
        drive(5'd12, 5'd0, 1, 0, 0, 5'd12, 1, 1, 5'd0, 0, 0, 0);
        for (int k = 0; k < CNT_MAX + 4; k++) begin
            #2; check_outs("sat", 1'b1, 1'b0);
            tick("sat", 1'b1);
        end
        check("sat/all_ones", 32'(stall_cycles), 32'(CNT_MAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
